handshake_sync: RTL and testbench

- Single-clock handshake bridge between the APB-side control path and the SPI engine.
- Samples the free-running spi_clk input and the SPI-side pready completion flag through synchronizer chains in the pclk domain.
- Converts an APB penable request into a spi_enable command aligned to an SPI clock rising edge.
- Returns a one-cycle spi_ready completion pulse to the APB side.

---
 rtl/handshake_sync.sv | 98 +++++++++
 tb/tb_handshake_sync.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/handshake_sync.sv
// Handshake bridge between the APB control path and the SPI engine.
// Synchronizes spi_clk and pready into pclk, and sequences the spi_enable and spi_ready handshake.
module handshake_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic pclk,
   input  logic preset,
   input  logic spi_clk,
   input  logic penable,
   input  logic pready,
   output logic spi_enable,
   output logic spi_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      ACTIVE = 2'd2,
      DONE   = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] rdy_sync;
   logic                   sclk_s;
   logic                   sclk_d;
   logic                   rdy_s;
   logic                   spi_tick;

   state_t state;
   state_t state_next;
   logic   spi_enable_next;
   logic   spi_ready_next;

   // Synchronizer chains; spi_clk is sampled as data only.
   always_ff @(posedge pclk) begin
      if (preset) begin
         sclk_sync <= '0;
         rdy_sync  <= '0;
         sclk_d    <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
         rdy_sync  <= {rdy_sync[SYNC_STAGES-2:0], pready};
         sclk_d    <= sclk_s;
      end
   end

   assign sclk_s   = sclk_sync[SYNC_STAGES-1];
   assign rdy_s    = rdy_sync[SYNC_STAGES-1];
   assign spi_tick = sclk_s & ~sclk_d;

   // State and output registers.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state      <= IDLE;
         spi_enable <= 1'b0;
         spi_ready  <= 1'b0;
      end else begin
         state      <= state_next;
         spi_enable <= spi_enable_next;
         spi_ready  <= spi_ready_next;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_next      = state;
      spi_enable_next = 1'b0;
      spi_ready_next  = 1'b0;
      unique case (state)
         IDLE: begin
            if (penable) state_next = REQ;
         end
         REQ: begin
            // An abort takes priority over a coincident SPI clock edge.
            if (!penable) begin
               state_next = IDLE;
            end else if (spi_tick) begin
               state_next      = ACTIVE;
               spi_enable_next = 1'b1;
            end
         end
         ACTIVE: begin
            if (rdy_s) begin
               state_next     = DONE;
               spi_ready_next = 1'b1;
            end else begin
               spi_enable_next = 1'b1;
            end
         end
         DONE: begin
            // Four-phase return to zero before accepting a new request.
            if (!penable && !rdy_s) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_handshake_sync.sv
// Directed self-checking bench for handshake_sync (SYNC_STAGES=2).
module tb_handshake_sync;

   logic pclk;
   logic preset;
   logic spi_clk;
   logic penable;
   logic pready;
   logic spi_enable;
   logic spi_ready;

   int checks;
   int errors;

   handshake_sync #(.SYNC_STAGES(2)) dut (
      .pclk       (pclk),
      .preset     (preset),
      .spi_clk    (spi_clk),
      .penable    (penable),
      .pready     (pready),
      .spi_enable (spi_enable),
      .spi_ready  (spi_ready)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   // Full transfer from IDLE with spi_clk=0 and pready=0 settled; leaves FSM in DONE.
   task automatic run_transfer(input string tag);
      penable = 1'b1;
      spi_clk = 1'b1;
      step(); check({tag, "_en_e1"}, spi_enable, 1'b0);
      step(); check({tag, "_en_e2"}, spi_enable, 1'b0);
      step(); check({tag, "_en_e3"}, spi_enable, 1'b1);
              check({tag, "_rdy_e3"}, spi_ready, 1'b0);
      pready = 1'b1;
      step(); check({tag, "_en_p1"}, spi_enable, 1'b1);
              check({tag, "_rdy_p1"}, spi_ready, 1'b0);
      step(); check({tag, "_en_p2"}, spi_enable, 1'b1);
              check({tag, "_rdy_p2"}, spi_ready, 1'b0);
      step(); check({tag, "_en_p3"}, spi_enable, 1'b0);
              check({tag, "_rdy_p3"}, spi_ready, 1'b1);
      step(); check({tag, "_en_p4"}, spi_enable, 1'b0);
              check({tag, "_rdy_p4"}, spi_ready, 1'b0);
   endtask

   task automatic settle_idle(input string tag);
      penable = 1'b0;
      pready  = 1'b0;
      spi_clk = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check({tag, "_en_settle"}, spi_enable, 1'b0);
         check({tag, "_rdy_settle"}, spi_ready, 1'b0);
      end
   endtask

   initial begin
      logic prev_rdy;
      checks  = 0;
      errors  = 0;
      preset  = 1'b1;
      penable = 1'b1;
      pready  = 1'b1;
      spi_clk = 1'b0;

      // Reset with every input active
      for (int i = 0; i < 3; i++) begin
         spi_clk = ~spi_clk;
         step();
         check("reset_en", spi_enable, 1'b0);
         check("reset_rdy", spi_ready, 1'b0);
      end
      preset = 1'b0;
      settle_idle("post_reset");

      run_transfer("basic");
      settle_idle("basic");

      // Abort before any SPI clock edge
      penable = 1'b1;
      step(); step();
      penable = 1'b0;
      step();
      spi_clk = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check("abort_en", spi_enable, 1'b0);
         check("abort_rdy", spi_ready, 1'b0);
      end
      settle_idle("abort");

      // Hold in DONE with pready and penable high
      run_transfer("hold");
      for (int i = 0; i < 10; i++) begin
         spi_clk = ~spi_clk;
         step();
         check("hold_en", spi_enable, 1'b0);
         check("hold_rdy", spi_ready, 1'b0);
      end
      settle_idle("hold");
      run_transfer("fresh");
      settle_idle("fresh");

      // Reset mid-transfer
      penable = 1'b1;
      spi_clk = 1'b1;
      step(); step(); step();
      check("midrst_pre_en", spi_enable, 1'b1);
      preset = 1'b1;
      pready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("midrst_en", spi_enable, 1'b0);
         check("midrst_rdy", spi_ready, 1'b0);
      end
      preset = 1'b0;
      settle_idle("midrst");

      // Random soak checking output invariants
      prev_rdy = 1'b0;
      for (int i = 0; i < 100; i++) begin
         penable = 1'($urandom_range(0, 1));
         pready  = 1'($urandom_range(0, 1));
         spi_clk = 1'($urandom_range(0, 1));
         preset  = ($urandom_range(0, 19) == 0);
         step();
         check("soak_exclusive", spi_enable & spi_ready, 1'b0);
         check("soak_pulse", prev_rdy & spi_ready, 1'b0);
         prev_rdy = spi_ready;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
